mult_matrix_collector: RTL and testbench
========================================

// Module: mult_matrix_collector
// PURPOSE
//  Sink stage directly downstream of the de-skew buffer at the systolic array output.
//  Each cycle it takes one de-skewed result row (size elements) qualified by input_valid.
//  It assembles size rows into a full result tile and presents the tile on a valid/ready handshake.
//  Two tile banks in ping-pong: one tile fills while the other waits for the consumer.
//  The source has no backpressure, so rows arriving with no free bank are dropped and flagged.
// PARAMETERS
//  data_size  4  bits per matrix element
//  size       3  matrix dimension: elements per row, rows per tile
// PORTS
//  clk            in   1                     single clock, all state updates on posedge
//  reset          in   1                     synchronous, active-high
//  input_stream   in   data_size*size        one de-skewed row; column c at [(size-c)*data_size-1 -: data_size]
//  input_valid    in   1                     input_stream holds a valid row this cycle
//  output_tile    out  data_size*size*size   tile; row r at [(size-r)*size*data_size-1 -: size*data_size]
//  output_valid   out  1                     output_tile holds a complete tile
//  output_ready   in   1                     consumer accepts the tile when output_valid & output_ready
//  overflow       out  1                     sticky: a row was dropped since reset
// BEHAVIOUR
//  - Reset (sync, active-high; wins over every other event in the cycle):
//    both banks EMPTY, bank data = 0, wr_bank = 0, rd_bank = 0, wr_row = 0,
//    output_valid = 0, output_tile = 0, overflow = 0. Any partially filled tile is discarded.
//  - Per-bank FSM (states EMPTY/FILLING/FULL):
//    EMPTY->FILLING: first row is written.
//    FILLING->FULL: row size-1 is written.
//    FULL->EMPTY: the tile is accepted (output_valid & output_ready).
//  - Write side:
//    On input_valid, if bank[wr_bank] is not FULL (registered state), store the row at row wr_row.
//    wr_row wraps size-1 -> 0; on the wrap, bank becomes FULL and wr_bank toggles.
//  - Drop rule:
//    On input_valid with bank[wr_bank] FULL, discard the row; no pointer moves; overflow <= 1.
//    overflow stays 1 until reset.
//  - Cycles with input_valid = 0 change no write-side state. Gaps between rows of a tile are legal.
//  - Read side:
//    output_valid = (bank[rd_bank] == FULL), registered.
//    output_tile = bank[rd_bank] data; it holds stable while output_valid & !output_ready.
//    On handshake: bank[rd_bank] -> EMPTY and rd_bank toggles. Tiles leave in arrival order.
//  - Latency: last row of a tile written at cycle N -> output_valid = 1 at cycle N+1 (bank idle).
//  - Freeing a bank takes effect the next cycle, with no same-cycle bypass.
//    A row arriving in the same cycle that its target bank is accepted is dropped (overflow set).
//  - Full throughput: with output_ready held 1, continuous input_valid never overflows.
//  - Arithmetic: none. Data is stored and forwarded bit-exact, with no sign or width change.
// TESTING (size=3, data_size=4)
//  1. Rows 0x123, 0x456, 0x789 on consecutive valid cycles, ready=1
//     -> next cycle output_valid=1, output_tile=0x123456789; the cycle after, output_valid=0.
//  2. Same three rows with 2 idle cycles between each -> identical tile; no premature output_valid.
//  3. ready=0, six rows (tiles A, B), then a seventh row
//     -> seventh row dropped, overflow=1; ready pulses yield A then B, then output_valid=0.
//  4. Nine back-to-back valid rows, ready=1 -> three tiles in order, overflow stays 0.
//  5. reset pulse after two rows of a tile -> output_valid=0, overflow=0;
//     the next three rows form a fresh tile with no stale data.
//  6. Both banks FULL; handshake on A in the same cycle a row arrives
//     -> row dropped, overflow=1; the following row lands in row 0 of A's bank.

Source files
------------

// File: rtl/mult_matrix_collector_if.sv
// mult_matrix_collector_if: row input, tile handshake and overflow flag of the result collector
interface mult_matrix_collector_if #(parameter int data_size = 4, parameter int size = 3);
  logic [data_size*size-1:0]      input_stream;
  logic                           input_valid;
  logic [data_size*size*size-1:0] output_tile;
  logic                           output_valid;
  logic                           output_ready;
  logic                           overflow;
  modport slave (input input_stream, input_valid, output_ready, output output_tile, output_valid, overflow);
  modport master (output input_stream, input_valid, output_ready, input output_tile, output_valid, overflow);
endinterface

// File: rtl/mult_matrix_collector.sv
// mult_matrix_collector: assembles de-skewed rows into tiles in two ping-pong banks behind a valid/ready port
module mult_matrix_collector #(
  parameter int data_size = 4,
  parameter int size = 3
) (
  input logic clk,
  input logic reset,
  mult_matrix_collector_if.slave bus
);
  localparam int rw = data_size * size;
  localparam int tw = rw * size;
  localparam int rb = size > 1 ? $clog2(size) : 1;
  localparam logic [1:0] st_empty = 2'd0, st_filling = 2'd1, st_full = 2'd2;
  logic [1:0]    state [2];
  logic [tw-1:0] data [2];
  logic          wr_bank, rd_bank;
  logic [rb-1:0] wr_row;
  logic          accept, write, last;
  // Write eligibility looks only at registered state, so a bank freed this cycle stays closed until next
  assign accept = bus.output_valid & bus.output_ready;
  assign write = bus.input_valid & (state[wr_bank] != st_full);
  assign last = wr_row == rb'(size - 1);
  assign bus.output_valid = state[rd_bank] == st_full;
  assign bus.output_tile = data[rd_bank];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        state[b] <= st_empty;
        data[b] <= '0;
      end
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_row <= '0;
      bus.overflow <= 1'b0;
    end else begin
      if (accept) begin
        state[rd_bank] <= st_empty;
        rd_bank <= ~rd_bank;
      end
      if (write) begin
        data[wr_bank][tw - 1 - int'(wr_row) * rw -: rw] <= bus.input_stream;
        state[wr_bank] <= last ? st_full : st_filling;
        wr_row <= last ? '0 : wr_row + rb'(1);
        if (last) wr_bank <= ~wr_bank;
      end
      if (bus.input_valid && !write) bus.overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mult_matrix_collector.sv
// tb_mult_matrix_collector: directed vector table plus hand-written overflow, reset and same-cycle-free sequences
module tb_mult_matrix_collector;
  logic clk, reset;
  int n_cmp, n_bad;
  mult_matrix_collector_if #(.data_size(4), .size(3)) bus ();
  mult_matrix_collector #(.data_size(4), .size(3)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [11:0] row;
    logic        vld;
    logic        rdy;
    logic        ev;
    logic [35:0] et;
    logic        eo;
    string       nm;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(input string nm, input logic [35:0] got, input logic [35:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic check_out(input string nm, input logic ev, input logic [35:0] et, input logic eo);
    chk({nm, ".valid"}, 36'(bus.output_valid), 36'(ev));
    if (ev) chk({nm, ".tile"}, bus.output_tile, et);
    chk({nm, ".overflow"}, 36'(bus.overflow), 36'(eo));
  endtask
  task automatic step(input logic [11:0] row, input logic vld, input logic rdy,
                      input logic ev, input logic [35:0] et, input logic eo, input string nm);
    bus.input_stream = row;
    bus.input_valid = vld;
    bus.output_ready = rdy;
    @(posedge clk);
    #1;
    check_out(nm, ev, et, eo);
  endtask
  task automatic add(input logic [11:0] row, input logic vld, input logic rdy,
                     input logic ev, input logic [35:0] et, input logic eo, input string nm);
    vec_t v;
    v.row = row; v.vld = vld; v.rdy = rdy; v.ev = ev; v.et = et; v.eo = eo; v.nm = nm;
    tbl.push_back(v);
  endtask
  initial begin
    n_cmp = 0;
    n_bad = 0;
    clk = 0;
    reset = 1;
    bus.input_stream = '0;
    bus.input_valid = 0;
    bus.output_ready = 0;
    @(posedge clk);
    #1;
    check_out("reset", 0, 36'h0, 0);
    chk("reset.tile", bus.output_tile, 36'h0);
    reset = 0;
    add(12'h123, 1, 1, 0, 0, 0, "t1.r0");
    add(12'h456, 1, 1, 0, 0, 0, "t1.r1");
    add(12'h789, 1, 1, 1, 36'h123456789, 0, "t1.r2");
    add(12'h000, 0, 1, 0, 0, 0, "t1.drain");
    add(12'h123, 1, 1, 0, 0, 0, "t2.r0");
    add(12'hfff, 0, 1, 0, 0, 0, "t2.gap0");
    add(12'hfff, 0, 1, 0, 0, 0, "t2.gap1");
    add(12'h456, 1, 1, 0, 0, 0, "t2.r1");
    add(12'hfff, 0, 1, 0, 0, 0, "t2.gap2");
    add(12'hfff, 0, 1, 0, 0, 0, "t2.gap3");
    add(12'h789, 1, 1, 1, 36'h123456789, 0, "t2.r2");
    add(12'h000, 0, 1, 0, 0, 0, "t2.drain");
    add(12'h111, 1, 1, 0, 0, 0, "t4.r1");
    add(12'h222, 1, 1, 0, 0, 0, "t4.r2");
    add(12'h333, 1, 1, 1, 36'h111222333, 0, "t4.r3");
    add(12'h444, 1, 1, 0, 0, 0, "t4.r4");
    add(12'h555, 1, 1, 0, 0, 0, "t4.r5");
    add(12'h666, 1, 1, 1, 36'h444555666, 0, "t4.r6");
    add(12'h777, 1, 1, 0, 0, 0, "t4.r7");
    add(12'h888, 1, 1, 0, 0, 0, "t4.r8");
    add(12'h999, 1, 1, 1, 36'h777888999, 0, "t4.r9");
    add(12'h000, 0, 1, 0, 0, 0, "t4.drain");
    foreach (tbl[i]) step(tbl[i].row, tbl[i].vld, tbl[i].rdy, tbl[i].ev, tbl[i].et, tbl[i].eo, tbl[i].nm);
    step(12'ha01, 1, 0, 0, 0, 0, "t3.a0");
    step(12'ha02, 1, 0, 0, 0, 0, "t3.a1");
    step(12'ha03, 1, 0, 1, 36'ha01a02a03, 0, "t3.a2");
    step(12'hb01, 1, 0, 1, 36'ha01a02a03, 0, "t3.b0");
    step(12'hb02, 1, 0, 1, 36'ha01a02a03, 0, "t3.b1");
    step(12'hb03, 1, 0, 1, 36'ha01a02a03, 0, "t3.b2");
    step(12'hc01, 1, 0, 1, 36'ha01a02a03, 1, "t3.drop");
    step(12'h000, 0, 1, 1, 36'hb01b02b03, 1, "t3.takeA");
    step(12'h000, 0, 0, 1, 36'hb01b02b03, 1, "t3.holdB");
    step(12'h000, 0, 1, 0, 0, 1, "t3.takeB");
    step(12'h311, 1, 1, 0, 0, 1, "t5.r0");
    step(12'h322, 1, 1, 0, 0, 1, "t5.r1");
    reset = 1;
    step(12'h3ff, 1, 1, 0, 0, 0, "t5.reset");
    chk("t5.reset.tile", bus.output_tile, 36'h0);
    reset = 0;
    step(12'habc, 1, 0, 0, 0, 0, "t5.f0");
    step(12'hdef, 1, 0, 0, 0, 0, "t5.f1");
    step(12'h0f1, 1, 0, 1, 36'habcdef0f1, 0, "t5.f2");
    step(12'h6b1, 1, 0, 1, 36'habcdef0f1, 0, "t6.b0");
    step(12'h6b2, 1, 0, 1, 36'habcdef0f1, 0, "t6.b1");
    step(12'h6b3, 1, 0, 1, 36'habcdef0f1, 0, "t6.b2");
    step(12'h6c1, 1, 1, 1, 36'h6b16b26b3, 1, "t6.drop");
    step(12'h6d1, 1, 0, 1, 36'h6b16b26b3, 1, "t6.d0");
    step(12'h6d2, 1, 0, 1, 36'h6b16b26b3, 1, "t6.d1");
    step(12'h6d3, 1, 0, 1, 36'h6b16b26b3, 1, "t6.d2");
    step(12'h000, 0, 1, 1, 36'h6d16d26d3, 1, "t6.takeB");
    step(12'h000, 0, 1, 0, 0, 1, "t6.takeA");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
